ctrl_word_decoder: RTL and testbench
====================================

# ctrl_word_decoder

Receive-side counterpart of the 16-bit control-word packer. It accepts packed control words over a valid/ready handshake and buffers them in a 2-entry FIFO. Each well-formed word is unpacked into registered field outputs (register selects a/b/c, carry-in, result code, PC/register enables), which a downstream datapath consumes via its own valid/ready handshake. Malformed words are dropped and counted.

## Interface
Parameters:
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- word_in  in  16  packed control word
- word_valid  in  1  word_in valid this cycle
- word_ready  out  1  decoder can accept a word this cycle
- flush  in  1  synchronous; discards all buffered words
- err_clear  in  1  synchronous; clears err_sticky and err_cnt
- out_valid  out  1  field outputs hold a decoded word
- out_ready  in  1  consumer accepts the current decoded word
- sel_a  out  3  word[14:12]
- sel_b  out  3  word[10:8]
- cin  out  1  word[7]
- sel_c  out  3  word[6:4]
- rec  out  2  word[3:2]
- pc_en  out  1  word[1], qualified: high only when out_valid
- reg_en  out  1  word[0], qualified: high only when out_valid
- err_sticky  out  1  set when a malformed word was accepted
- err_cnt  out  ERR_W  number of malformed words, saturating

## Operation
- Word format: bit15 and bit11 are reserved zero. A word is malformed if either bit is 1.
- Accept = word_valid & word_ready. word_ready = !flush & (fifo_count < 2).
- Malformed accepted word: not stored. Set err_sticky and increment err_cnt, saturating at 2^ERR_W-1.
- Well-formed accepted word: enters the pipeline in order. Storage is 2 FIFO entries plus the output register, 3 words total.
- Fire = out_valid & out_ready. The output register loads when it is empty or firing.
- Output register load source: the FIFO head if the FIFO is non-empty. Otherwise the incoming word (bypass) if a well-formed word is accepted this cycle. Otherwise out_valid is cleared.
- An incoming word goes to the FIFO tail when it is not bypassed. FIFO simultaneous push/pop keeps the count unchanged.
- Strict FIFO ordering. A word is never duplicated or reordered.
- flush: next edge clears fifo_count and out_valid. Input is not accepted in the flush cycle. err state is unaffected.
- err_clear together with a new malformed accept: result is err_sticky=1, err_cnt=1.
- Field outputs hold their last value when out_valid=0, except pc_en and reg_en, which are forced to 0.
- Reset values: out_valid=0, all fields 0, pc_en=0, reg_en=0, err_sticky=0, err_cnt=0, fifo empty. word_ready=1 once reset is released.
- Reset asserted mid-operation discards all buffered words immediately (asynchronous).

## Timing
- Latency: a well-formed word accepted at edge N into an empty pipeline shows out_valid=1 with its fields after edge N (bypass, 1 cycle).
- Throughput: 1 word/cycle when out_ready is held high. word_ready stays 1.
- With out_ready=0: the output register plus the 2 FIFO entries fill after 3 accepts, then word_ready=0. word_ready returns to 1 the cycle after the first fire.
- Backpressure propagation: word_ready depends on registered fifo_count and on flush only. There is no combinational path from out_ready to word_ready.
- Error counting: err_sticky and err_cnt update at the edge of the accepting cycle.

## Test plan
- Single word: word_in=16'h53EA with out_ready=1 -> next cycle out_valid=1, sel_a=5, sel_b=3, cin=1, sel_c=6, rec=2, pc_en=1, reg_en=0. The following cycle out_valid=0 and pc_en=0.
- Backpressure: out_ready=0, send 16'h1000, 16'h2000, 16'h3000, 16'h4000 -> word_ready drops after the 3rd accept and the 4th word is held. Then raise out_ready -> sel_a sequence 1,2,3,4 with no loss or duplication.
- Malformed: send 16'h8000, then 16'h0800, then 16'h0003 -> err_cnt=2, err_sticky=1. The only output is pc_en=1, reg_en=1 for 16'h0003.
- Saturation and clear: send 300 words of 16'h8000 -> err_cnt=255. Then err_clear together with 16'h0800 -> err_cnt=1, err_sticky=1.
- Flush: with 3 words buffered, pulse flush -> out_valid=0 next cycle, word_ready=0 during the flush cycle, and no stale word appears afterwards.
- Reset mid-stream: assert reset asynchronously between edges while 2 words are buffered -> all outputs drop to 0 immediately. After release the first new word 16'h53EA decodes correctly with 1-cycle latency.

Source files
------------

// File: rtl/ctrl_word_decoder.sv
// ctrl_word_decoder: unpacks valid/ready 16-bit control words through a 2-entry FIFO into registered fields (sel_a/sel_b/cin/sel_c/rec/pc_en/reg_en); malformed words are dropped and counted in err_sticky/err_cnt
module ctrl_word_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             flush,
  input  logic             err_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       sel_a,
  output logic [2:0]       sel_b,
  output logic             cin,
  output logic [2:0]       sel_c,
  output logic [1:0]       rec,
  output logic             pc_en,
  output logic             reg_en,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);
  logic [15:0] mem [2];
  logic [15:0] out_word;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  cnt;
  logic        acc, bad, good, fire, load, pop, bypass, push;
  assign word_ready = reset & !flush & (cnt != 2'd2);
  assign acc        = word_valid & word_ready;
  assign bad        = word_in[15] | word_in[11];
  assign good       = acc & !bad;
  assign fire       = out_valid & out_ready;
  assign load       = !out_valid | fire;
  assign pop        = load & (cnt != 2'd0);
  assign bypass     = load & (cnt == 2'd0) & good;
  assign push       = good & !bypass;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= 16'd0;
    end else if (flush) begin
      cnt       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
      if (load) out_valid <= pop | bypass;
      if (pop | bypass) out_word <= pop ? mem[rd_ptr] : word_in;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clear) begin
      err_sticky <= acc & bad;
      err_cnt    <= ERR_W'(acc & bad);
    end else if (acc & bad) begin
      err_sticky <= 1'b1;
      err_cnt    <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
    end
  assign sel_a  = out_word[14:12];
  assign sel_b  = out_word[10:8];
  assign cin    = out_word[7];
  assign sel_c  = out_word[6:4];
  assign rec    = out_word[3:2];
  assign pc_en  = out_valid & out_word[1];
  assign reg_en = out_valid & out_word[0];
endmodule

// File: tb/tb_ctrl_word_decoder.sv
// tb_ctrl_word_decoder: randomized and directed checks of ctrl_word_decoder against a queue-based model
module tb_ctrl_word_decoder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] word_in = 16'd0;
  logic        word_valid = 1'b0, flush = 1'b0, err_clear = 1'b0, out_ready = 1'b0;
  logic        word_ready, out_valid, cin, pc_en, reg_en, err_sticky;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic [1:0]  rec;
  logic [7:0]  err_cnt;
  int compared = 0, mismatched = 0;

  ctrl_word_decoder #(.ERR_W(8)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .err_clear(err_clear),
    .out_valid(out_valid), .out_ready(out_ready), .sel_a(sel_a), .sel_b(sel_b),
    .cin(cin), .sel_c(sel_c), .rec(rec), .pc_en(pc_en), .reg_en(reg_en),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = !clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] q[$];
  logic [15:0] last = 16'd0;
  logic        m_es = 1'b0;
  logic [7:0]  m_ec = 8'd0;

  // Whole pipeline (output register + FIFO) seen as one in-order queue of up to 3 words
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      last = 16'd0;
      m_es = 1'b0;
      m_ec = 8'd0;
    end else begin
      logic rdy, acc, bad, fire;
      rdy  = !flush && q.size() < 3;
      acc  = word_valid && rdy;
      bad  = word_in[15] || word_in[11];
      fire = q.size() > 0 && out_ready;
      if (flush) q.delete();
      else begin
        if (fire) void'(q.pop_front());
        if (acc && !bad) q.push_back(word_in);
      end
      if (q.size() > 0) last = q[0];
      if (err_clear) begin
        m_es = acc && bad;
        m_ec = (acc && bad) ? 8'd1 : 8'd0;
      end else if (acc && bad) begin
        m_es = 1'b1;
        if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    logic v;
    v = q.size() > 0;
    chk("word_ready", word_ready, reset && !flush && q.size() < 3);
    chk("out_valid", out_valid, v);
    chk("fields", {sel_a, sel_b, cin, sel_c, rec},
        {last[14:12], last[10:8], last[7], last[6:4], last[3:2]});
    chk("pc_en", pc_en, v && last[1]);
    chk("reg_en", reg_en, v && last[0]);
    chk("err_sticky", err_sticky, m_es);
    chk("err_cnt", err_cnt, m_ec);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input logic ordy);
    word_in = w;
    word_valid = 1'b1;
    out_ready = ordy;
    cyc();
    word_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] got[$];
    logic [2:0] exp_seq[4];
    logic acc;
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4};
    #12;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset err_cnt", err_cnt, 8'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    cyc();
    chk("ready after reset", word_ready, 1'b1);

    send(16'h53EA, 1'b1);
    chk("single out_valid", out_valid, 1'b1);
    chk("single fields", {sel_a, sel_b, cin, sel_c, rec, pc_en, reg_en},
        {3'd5, 3'd3, 1'b1, 3'd6, 2'd2, 1'b1, 1'b0});
    cyc();
    chk("single drained", {out_valid, pc_en}, 2'b00);
    chk("single hold sel_a", sel_a, 3'd5);

    send(16'h1000, 1'b0);
    send(16'h2000, 1'b0);
    chk("ready after 2", word_ready, 1'b1);
    send(16'h3000, 1'b0);
    chk("ready after 3", word_ready, 1'b0);
    word_in = 16'h4000;
    word_valid = 1'b1;
    cyc();
    chk("held 4th", word_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(sel_a);
      acc = word_valid && word_ready;
      cyc();
      if (acc) word_valid = 1'b0;
    end
    chk("bp count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp order", got[i], exp_seq[i]);

    send(16'h8000, 1'b1);
    send(16'h0800, 1'b1);
    chk("malformed no output", out_valid, 1'b0);
    send(16'h0003, 1'b1);
    chk("malformed err_cnt", err_cnt, 8'd2);
    chk("malformed sticky", err_sticky, 1'b1);
    chk("good after bad", {out_valid, pc_en, reg_en}, 3'b111);

    for (int i = 0; i < 300; i++) send(16'h8000, 1'b1);
    chk("saturated", err_cnt, 8'hFF);
    err_clear = 1'b1;
    send(16'h0800, 1'b1);
    err_clear = 1'b0;
    chk("clear+bad cnt", err_cnt, 8'd1);
    chk("clear+bad sticky", err_sticky, 1'b1);

    send(16'h1001, 1'b0);
    send(16'h2002, 1'b0);
    send(16'h3003, 1'b0);
    flush = 1'b1;
    word_in = 16'h4004;
    word_valid = 1'b1;
    #1;
    chk("flush ready", word_ready, 1'b0);
    cyc();
    flush = 1'b0;
    word_valid = 1'b0;
    chk("flush out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no stale", out_valid, 1'b0);
    end

    send(16'h1111 & 16'h77FF, 1'b0);
    send(16'h2222 & 16'h77FF, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("async reset outs", {out_valid, sel_a, sel_b, cin, sel_c, rec, pc_en, reg_en, err_sticky, err_cnt}, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    cyc();
    send(16'h53EA, 1'b1);
    chk("post reset decode", {out_valid, sel_a, sel_b, cin, sel_c, rec, pc_en, reg_en},
        {1'b1, 3'd5, 3'd3, 1'b1, 3'd6, 2'd2, 1'b1, 1'b0});

    for (int i = 0; i < 600; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(3) != 0) w = w & 16'h77FF;
      word_in = w;
      word_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      flush = $urandom_range(30) == 0;
      err_clear = $urandom_range(40) == 0;
      cyc();
    end
    word_valid = 1'b0;
    flush = 1'b0;
    err_clear = 1'b0;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
